ram512_arbiter: RTL
===================

// Module: ram512_arbiter
// PURPOSE
//  Shares one RAM512 (16-bit x 512, write on clock edge when load=1, out = word at address
//  combinationally) between two requesters (r0, r1) via req/ack handshake, round-robin.
//  Also runs a bulk-clear sequence that writes CLEAR_VALUE to all 512 words.
//  Sits between RAM512 and its clients (CPU-side port, DMA-side port); drives RAM512 pins directly.
// PARAMETERS
//  ADDR_W       9        RAM address width; clear counts 0 .. 2**ADDR_W-1
//  DATA_W       16       RAM word width
//  CLEAR_VALUE  16'd0    word written to every location during clear
// PORTS
//  clock        in   1       single clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  rN_req       in   1       (N=0,1) request; held high with command stable until rN_ack
//  rN_load      in   1       1 = write rN_in, 0 = read
//  rN_address   in   ADDR_W  target word
//  rN_in        in   DATA_W  write data
//  rN_ack       out  1       one-cycle completion pulse
//  rN_out       out  DATA_W  read data, registered, valid while rN_ack=1, held until next read by N
//  clear_start  in   1       pulse: request bulk clear
//  busy         out  1       1 in any state except IDLE
//  clear_done   out  1       one-cycle pulse after last clear write
//  ram_in       out  DATA_W  to RAM512 in
//  ram_address  out  ADDR_W  to RAM512 address
//  ram_load     out  1       to RAM512 load
//  ram_out      in   DATA_W  from RAM512 out
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (r0 wins first tie), clear_pend=0, cnt=0; all outputs 0
//   (ack, clear_done, busy, ram_load, ram_address, ram_in, rN_out). RAM contents untouched.
//  States: IDLE, ACCESS, RESP, CLEAR.
//  IDLE: at edge, clear_pend|clear_start -> CLEAR; else any req -> ACCESS with grant from picker;
//   granted rN_load/address/in captured into cmd regs at that edge. Clear beats requests.
//  ACCESS (exactly 1 cycle): ram_address=cmd_addr, ram_in=cmd_data, ram_load=cmd_load.
//   Edge ending ACCESS: RAM write commits; for reads rN_out<=ram_out; -> RESP.
//  RESP (1 cycle): ack of granted requester =1; ram_load=0. Granted requester's req ignored
//   this cycle (it drops req on seeing ack). At edge: clear pending -> CLEAR; else other
//   requester's req -> ACCESS for it (capture its cmd); else IDLE.
//  Latency: req seen at edge E -> ack high in cycle E+2; max throughput 1 access / 2 cycles.
//  Round-robin: both req in same cycle -> grant the one != last_grant; last_grant updates on grant.
//   Single requester with req held continuously gets access every 3 cycles (via IDLE).
//  clear_start in ACCESS/RESP: sets clear_pend; clear begins after RESP. In CLEAR: ignored.
//  CLEAR: ram_load=1, ram_in=CLEAR_VALUE, ram_address=cnt; cnt increments each edge;
//   512 cycles; at edge with cnt=511: clear_done pulses next cycle, cnt wraps to 0, ->IDLE
//   (or ACCESS if req pending). Requests stall (no ack) while CLEAR.
//  Outside ACCESS/CLEAR: ram_load=0, ram_address=0, ram_in=0 (never a stray write).
//  Reset mid-operation (any state): returns to reset values next edge; an in-flight write
//   completes only if its ACCESS-ending edge was not the reset edge; no ack issued;
//   partial clear not resumed.
//  Requester changing command while req high and unacked: undefined; assert in sim.
// STRUCTURE
//  State encodings and ADDR_W/DATA_W defaults as `defines in the chapter shared header
//  (ch03 defs), reused by RAM controllers for RAM8..RAM16K.
//  Sub-module: rr_arbiter2 (inputs req0, req1, last_grant, mask; outputs grant_valid, grant_id),
//  combinational. Datapath, counter, FSM in ram512_arbiter. Bench instantiates real RAM512.
// TESTING
//  1 reset, r0 write addr=128 in=15, then r0 read 128 -> ack at E+2 each, r0_out=15.
//  2 r0,r1 req same edge (r0 wr 5<=111, r1 wr 6<=222) -> r0 acked first, r1 acked 2 cycles
//    later; reads of 5,6 return 111,222; next tie goes r0 (last=r1).
//  3 write 0..511 with 16*addr+1, clear_start -> busy 512+ cycles, clear_done once, reads of
//    addr 0,16,...,496 all return 0; req during clear acked only after clear_done.
//  4 clear_start during r1 ACCESS -> r1 acked normally, CLEAR begins next edge, no lost request.
//  5 reset asserted at cnt=200 in CLEAR -> idle next cycle, busy=0, ram_load=0, no clear_done;
//    addr 199 reads 0, addr 300 keeps old value.

Source files
------------

// File: rtl/ram512_arbiter_pkg.sv
// Shared definitions for the RAM512 arbiter: default geometry and FSM state encoding.
package ram512_arbiter_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 16;

  // IDLE waits for work, ACCESS drives the RAM for one cycle, RESP acknowledges,
  // CLEAR sweeps every word with the clear value.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

endpackage

// File: rtl/ram512_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. A masked requester is treated as not requesting.
// On a tie the requester that was not granted last wins.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic       grant_valid,
  output logic       grant_id
);

  logic eff0;
  logic eff1;

  // Pick a winner among the unmasked requests.
  always_comb begin
    eff0        = req0 & ~mask[0];
    eff1        = req1 & ~mask[1];
    grant_valid = eff0 | eff1;
    if (eff0 && eff1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = eff1;
    end
  end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one RAM512 between two requesters (round-robin) and runs a bulk clear
// that writes CLEAR_VALUE to every word.
//
// Handshake: a requester raises rN_req with rN_load/rN_address/rN_in and keeps
// all of them stable until it sees rN_ack. rN_ack is a one-cycle pulse; read
// data on rN_out is valid in that cycle and held until that requester's next
// read. The requester drops rN_req in response to the ack.
module ram512_arbiter
  import ram512_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = RAM_ADDR_W,
  parameter int                DATA_W      = RAM_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_load,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_in,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_out,
  input  logic              r1_req,
  input  logic              r1_load,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_in,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_out,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              clear_pend;
  logic              gid;
  logic              take;
  logic              cmd_load;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        arb_mask;
  logic              grant_valid;
  logic              grant_id;
  logic              sel_load;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              clear_go;

  // In RESP the requester being acknowledged is still holding req; hide it.
  always_comb begin
    arb_mask = 2'b00;
    if (state == ST_RESP) begin
      arb_mask = gid ? 2'b10 : 2'b01;
    end
  end

  rr_arbiter2 u_rr (
    .req0        (r0_req),
    .req1        (r1_req),
    .last_grant  (last_grant),
    .mask        (arb_mask),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Command of whichever requester the picker selects.
  always_comb begin
    sel_load = grant_id ? r1_load    : r0_load;
    sel_addr = grant_id ? r1_address : r0_address;
    sel_data = grant_id ? r1_in      : r0_in;
    clear_go = clear_pend | clear_start;
  end

  // Next state; clear always beats requests, take marks a grant to capture.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_go) begin
          state_nxt = ST_CLEAR;
        end else if (grant_valid) begin
          state_nxt = ST_ACCESS;
          take      = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (clear_go) begin
          state_nxt = ST_CLEAR;
        end else if (grant_valid) begin
          state_nxt = ST_ACCESS;
          take      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt == CNT_LAST) begin
          if (grant_valid) begin
            state_nxt = ST_ACCESS;
            take      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RAM pins and status. Load is gated by reset so a reset edge never commits a write.
  always_comb begin
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    if (state == ST_ACCESS) begin
      ram_load    = cmd_load & ~reset;
      ram_address = cmd_addr;
      ram_in      = cmd_data;
    end else if (state == ST_CLEAR) begin
      ram_load    = ~reset;
      ram_address = cnt;
      ram_in      = CLEAR_VALUE;
    end
    r0_ack    = (state == ST_RESP) && !gid;
    r1_ack    = (state == ST_RESP) && gid;
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  // State register, command capture, read-data capture, clear counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      clear_pend <= 1'b0;
      cnt        <= '0;
      gid        <= 1'b0;
      cmd_load   <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      r0_out     <= '0;
      r1_out     <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= (state == ST_CLEAR) && (cnt == CNT_LAST);
      if (take) begin
        gid        <= grant_id;
        last_grant <= grant_id;
        cmd_load   <= sel_load;
        cmd_addr   <= sel_addr;
        cmd_data   <= sel_data;
      end
      if (state == ST_ACCESS && !cmd_load) begin
        if (gid) begin
          r1_out <= ram_out;
        end else begin
          r0_out <= ram_out;
        end
      end
      if (state == ST_CLEAR) begin
        cnt <= cnt + ADDR_W'(1);
      end
      if (state == ST_ACCESS && clear_start) begin
        clear_pend <= 1'b1;
      end else if (state_nxt == ST_CLEAR) begin
        clear_pend <= 1'b0;
      end
    end
  end

  // A requester must not change its command while waiting for its ack.
  r0_cmd_stable: assert property (@(posedge clock) disable iff (reset)
    (r0_req && !r0_ack && $past(r0_req && !r0_ack)) |-> $stable({r0_load, r0_address, r0_in}));
  r1_cmd_stable: assert property (@(posedge clock) disable iff (reset)
    (r1_req && !r1_ack && $past(r1_req && !r1_ack)) |-> $stable({r1_load, r1_address, r1_in}));

endmodule
